multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle control sequencer for the RV32 subset core. It sits between the instruction register/decoder fields and the datapath (PC, register file, ALU, memory port). It steps each instruction through FETCH/DECODE/EXEC/MEM/WB, drives all datapath enables and selects, handshakes with instruction and data memory, counts retired instructions and traps on illegal encodings.

Parameters:
ALU_OP_W, 4, width of alu_op.
CNT_W, 32, width of retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  start/continue execution; sampled in IDLE only
opcode  in  7  instruction bits [6:0] from IR
func3  in  3  instruction bits [14:12] from IR
func7  in  7  instruction bits [31:25] from IR
alu_zero  in  1  ALU result == 0
ifetch_ready  in  1  instruction memory data valid this cycle
dmem_ready  in  1  data memory access complete this cycle
ifetch_req  out  1  instruction fetch request
ir_write  out  1  load IR and latch old PC
pc_write  out  1  PC load enable
pc_src  out  2  00 pc+4, 01 branch target, 10 JAL target
alu_src_imm  out  1  ALU operand B = immediate
alu_op  out  ALU_OP_W  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLL, 5 SRL, 6 SLT
dmem_req  out  1  data memory request
dmem_we  out  1  data memory write (valid with dmem_req)
reg_write  out  1  register file write enable
wb_sel  out  2  00 ALU result, 01 memory data, 10 old PC+4
retire  out  1  one-cycle pulse on instruction completion
instr_count  out  CNT_W  retired-instruction count
trap  out  1  illegal instruction seen; sticky
state_o  out  3  current state, for debug LEDs

Behaviour:
- States (3-bit): IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=7. Registered state; all outputs decoded from state + IR fields (Moore/Mealy on IR only, never on ready inputs except where noted).
- Reset (async, rst_n=0): state=IDLE, instr_count=0, trap=0; every output 0, alu_op=0, pc_src=00, wb_sel=00.
- IDLE: run=1 -> FETCH, else stay.
- FETCH: ifetch_req=1 held until ifetch_ready. In the ready cycle: ir_write=1, pc_write=1, pc_src=00 -> DECODE. No IR/PC change while waiting.
- DECODE: one cycle, register read. Legal set: R-type 0110011 ADD(f3 0,f7 0) SUB(f3 0,f7 0x20) SLL(1,0) SLT(2,0) SRL(5,0) OR(6,0) AND(7,0); I-type 0010011 ADDI(f3 0) ORI(6) ANDI(7); LW 0000011 f3 2; SW 0100011 f3 2; BEQ 1100011 f3 0; BNE f3 1; JAL 1101111 (func3 ignored). Illegal -> TRAP, else EXEC.
- EXEC: alu_op per instruction; alu_src_imm=1 for I-type/LW/SW.
  R/I -> WB.
  LW/SW: alu_op=ADD -> MEM.
  Branch: alu_op=SUB; taken = alu_zero (BEQ) or !alu_zero (BNE); if taken pc_write=1, pc_src=01; retire=1 -> FETCH.
  JAL: pc_write=1, pc_src=10, reg_write=1, wb_sel=10, retire=1 -> FETCH.
- MEM: dmem_req=1, dmem_we=1 for SW, held until dmem_ready. On ready: SW retire=1 -> FETCH; LW -> WB.
- WB: reg_write=1, wb_sel=01 for LW else 00; retire=1 -> FETCH.
- Zero-wait latency: R/I 4 cycles, LW 5, SW 4, branch/JAL 3.
- instr_count += 1 on every retire; wraps to 0 from all-ones.
- TRAP: trap=1, all enables 0, stays until reset; run ignored. No retire.
- run deasserted mid-instruction has no effect; it is checked only in IDLE. Never returns to IDLE except by reset.
- Reset asserted mid-handshake: request drops immediately (async), no partial write; memories must tolerate an abandoned request.
- ready inputs outside the matching request state are ignored.

Decomposition:
- Shared package/header rv_ctrl_defs: opcode constants, func3/func7 constants, ALU_OP codes, state encodings, pc_src/wb_sel codes; shared with decode and ALU.
- One sub-module: rv_inst_class (combinational): classifies opcode/func3/func7 into class (RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL), alu_op and legal flag. The FSM, counter and trap logic stay in multicycle_ctrl.

Test Plan:
- Reset then run=1, ADD x3,x1,x2 (0x002081B3), zero-wait memory -> states 1,2,3,5; reg_write and retire in cycle 4; instr_count=1.
- LW (0x0000A183), dmem_ready delayed 3 cycles -> dmem_req high 4 cycles with dmem_we=0, then WB with wb_sel=01; 8 cycles total including fetch.
- BEQ with alu_zero=1, then alu_zero=0 -> pc_write=1/pc_src=01 in EXEC first time only; retire both times; 3 cycles each.
- JAL (0x008000EF) -> EXEC: pc_src=10, reg_write=1, wb_sel=10, retire; next state FETCH.
- Illegal: opcode 0110011, f3 0, f7 0x01 -> TRAP after DECODE; trap=1 sticky, no retire, instr_count unchanged, run toggling ignored.
- rst_n pulsed low during MEM wait of SW -> dmem_req falls in the same cycle; state IDLE, instr_count=0, trap=0.

Source files
------------

// File: rtl/rv_ctrl_defs.sv
// rv_ctrl_defs: shared encodings for the RV32 subset multi-cycle controller.
package rv_ctrl_defs;
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_e;
  typedef enum logic [2:0] {C_RTYPE, C_ITYPE, C_LOAD, C_STORE, C_BRANCH, C_JAL} iclass_e;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SLT = 3'd2;
  localparam logic [2:0] F3_SRL = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_W   = 3'd2;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_SUB  = 7'h20;
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_SLL = 4'd4;
  localparam logic [3:0] ALU_SRL = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JAL = 2'b10;
  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction and data memory request/ready handshake.
interface multicycle_ctrl_if;
  logic ifetch_req;
  logic ifetch_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;
  modport master (output ifetch_req, dmem_req, dmem_we, input ifetch_ready, dmem_ready);
  modport slave (input ifetch_req, dmem_req, dmem_we, output ifetch_ready, dmem_ready);
endinterface

// File: rtl/rv_inst_class.sv
// rv_inst_class: classifies IR fields into instruction class, ALU op and legality.
module rv_inst_class
  import rv_ctrl_defs::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  output iclass_e    cls,
  output logic [3:0] alu_op,
  output logic       legal
);
  always_comb begin
    cls = C_RTYPE;
    alu_op = ALU_ADD;
    legal = 1'b0;
    case (opcode)
      OP_R: begin
        legal = func7 == F7_BASE;
        case (func3)
          F3_ADD: begin
            alu_op = func7 == F7_SUB ? ALU_SUB : ALU_ADD;
            legal = func7 == F7_BASE || func7 == F7_SUB;
          end
          F3_SLL: alu_op = ALU_SLL;
          F3_SLT: alu_op = ALU_SLT;
          F3_SRL: alu_op = ALU_SRL;
          F3_OR:  alu_op = ALU_OR;
          F3_AND: alu_op = ALU_AND;
          default: legal = 1'b0;
        endcase
      end
      OP_I: begin
        cls = C_ITYPE;
        legal = func3 == F3_ADD || func3 == F3_OR || func3 == F3_AND;
        alu_op = func3 == F3_OR ? ALU_OR : func3 == F3_AND ? ALU_AND : ALU_ADD;
      end
      OP_LOAD: begin
        cls = C_LOAD;
        legal = func3 == F3_W;
      end
      OP_STORE: begin
        cls = C_STORE;
        legal = func3 == F3_W;
      end
      OP_BRANCH: begin
        cls = C_BRANCH;
        legal = func3 == F3_BEQ || func3 == F3_BNE;
        alu_op = ALU_SUB;
      end
      OP_JAL: begin
        cls = C_JAL;
        legal = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer driving datapath controls,
// memory handshakes, retired-instruction counter and sticky illegal-instruction trap.
module multicycle_ctrl
  import rv_ctrl_defs::*;
#(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [6:0]          opcode,
  input  logic [2:0]          func3,
  input  logic [6:0]          func7,
  input  logic                alu_zero,
  multicycle_ctrl_if.master   mem,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                alu_src_imm,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                reg_write,
  output logic [1:0]          wb_sel,
  output logic                retire,
  output logic [CNT_W-1:0]    instr_count,
  output logic                trap,
  output logic [2:0]          state_o
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  iclass_e           cls;
  logic [3:0]        cls_op;
  logic              legal;
  logic              taken;
  rv_inst_class u_class (
    .opcode (opcode),
    .func3  (func3),
    .func7  (func7),
    .cls    (cls),
    .alu_op (cls_op),
    .legal  (legal)
  );
  assign taken = (func3 == F3_BNE) ^ alu_zero;
  always_comb begin
    state_d = state_q;
    mem.ifetch_req = 1'b0;
    mem.dmem_req = 1'b0;
    mem.dmem_we = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src = PC_SEQ;
    alu_src_imm = 1'b0;
    alu_op = '0;
    reg_write = 1'b0;
    wb_sel = WB_ALU;
    retire = 1'b0;
    case (state_q)
      S_IDLE: state_d = run ? S_FETCH : S_IDLE;
      S_FETCH: begin
        mem.ifetch_req = 1'b1;
        ir_write = mem.ifetch_ready;
        pc_write = mem.ifetch_ready;
        state_d = mem.ifetch_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        alu_op = ALU_OP_W'(cls_op);
        alu_src_imm = cls inside {C_ITYPE, C_LOAD, C_STORE};
        state_d = S_FETCH;
        case (cls)
          C_RTYPE, C_ITYPE: state_d = S_WB;
          C_LOAD, C_STORE:  state_d = S_MEM;
          C_BRANCH: begin
            pc_write = taken;
            pc_src = taken ? PC_BR : PC_SEQ;
            retire = 1'b1;
          end
          C_JAL: begin
            pc_write = 1'b1;
            pc_src = PC_JAL;
            reg_write = 1'b1;
            wb_sel = WB_PC4;
            retire = 1'b1;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem.dmem_req = 1'b1;
        mem.dmem_we = cls == C_STORE;
        retire = mem.dmem_ready && cls == C_STORE;
        state_d = !mem.dmem_ready ? S_MEM : cls == C_STORE ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel = cls == C_LOAD ? WB_MEM : WB_ALU;
        retire = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: ;
      default: state_d = S_IDLE;
    endcase
  end
  assign cnt_d = cnt_q + CNT_W'(retire);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
  end
  assign instr_count = cnt_q;
  assign trap = state_q == S_TRAP;
  assign state_o = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream with random memory wait states,
// checked per retired instruction against a reference model via a scoreboard queue.
module tb_multicycle_ctrl;
  localparam int CW = 4;
  localparam int AOP [15] = '{0, 1, 4, 6, 5, 3, 2, 0, 3, 2, 0, 0, 1, 1, 0};
  localparam int K_ADD = 0, K_LW = 10, K_SW = 11, K_BEQ = 12, K_JAL = 14;
  typedef struct {
    int lat;
    int mcyc;
    logic rw, pw, we, imm, chk_alu;
    logic [1:0] wb, ps;
    logic [3:0] aop;
    logic [CW-1:0] cnt;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, run = 1'b0, alu_zero = 1'b0;
  logic [6:0] opcode = '0, func7 = '0;
  logic [2:0] func3 = '0;
  logic ir_write, pc_write, alu_src_imm, reg_write, retire, trap;
  logic [1:0] pc_src, wb_sel;
  logic [3:0] alu_op;
  logic [CW-1:0] instr_count;
  logic [2:0] state_o;
  int tests = 0, fails = 0, n_ret = 0;
  exp_t sbq [$];
  multicycle_ctrl_if mif ();
  multicycle_ctrl #(.ALU_OP_W(4), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .func3(func3), .func7(func7),
    .alu_zero(alu_zero), .mem(mif), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .alu_src_imm(alu_src_imm), .alu_op(alu_op), .reg_write(reg_write), .wb_sel(wb_sel),
    .retire(retire), .instr_count(instr_count), .trap(trap), .state_o(state_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic void enc(input int k, output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
    f7 = 7'h00;
    op = k <= 6 ? 7'b0110011 : k <= 9 ? 7'b0010011 : k == 10 ? 7'b0000011 : k == 11 ? 7'b0100011 :
         k <= 13 ? 7'b1100011 : 7'b1101111;
    case (k)
      0: f3 = 3'd0;
      1: begin f3 = 3'd0; f7 = 7'h20; end
      2: f3 = 3'd1;
      3: f3 = 3'd2;
      4: f3 = 3'd5;
      5: f3 = 3'd6;
      6: f3 = 3'd7;
      7: f3 = 3'd0;
      8: f3 = 3'd6;
      9: f3 = 3'd7;
      10, 11: f3 = 3'd2;
      12: f3 = 3'd0;
      13: f3 = 3'd1;
      default: f3 = 3'($urandom);
    endcase
    if (k >= 7) f7 = 7'($urandom);
  endfunction
  function automatic void illeg(input int i, output logic [6:0] op, output logic [2:0] f3, output logic [6:0] f7);
    f7 = 7'h00;
    case (i)
      0: begin op = 7'b0110011; f3 = 3'd0; f7 = 7'h01; end
      1: begin op = 7'b0110011; f3 = 3'd3; end
      2: begin op = 7'b0010011; f3 = 3'd1; end
      3: begin op = 7'b0000011; f3 = 3'd0; end
      4: begin op = 7'b0100011; f3 = 3'd1; end
      5: begin op = 7'b1100011; f3 = 3'd2; end
      default: begin op = 7'b0000000; f3 = 3'd0; end
    endcase
  endfunction
  task automatic wait_fetch;
    int c = 0;
    while (!mif.ifetch_req && c < 30) begin step(); c++; end
    chk("ifetch_req_seen", mif.ifetch_req, 1);
  endtask
  task automatic fetch(input int fw);
    repeat (fw) begin mif.dmem_ready = 1'($urandom); step(); end
    mif.dmem_ready = 1'b0;
    mif.ifetch_ready = 1'b1;
    step();
    mif.ifetch_ready = 1'b0;
  endtask
  task automatic wait_dmem;
    int c = 0;
    while (!mif.dmem_req && c < 30) begin step(); c++; end
    chk("dmem_req_seen", mif.dmem_req, 1);
  endtask
  task automatic issue(input int k, input int fw, input int mw, input bit z);
    exp_t e;
    bit tk, m;
    wait_fetch();
    enc(k, opcode, func3, func7);
    alu_zero = z;
    m = k == K_LW || k == K_SW;
    tk = (k == 12 && z) || (k == 13 && !z);
    e.lat = (k <= 9 ? 4 : k == K_LW ? 5 : k == K_SW ? 4 : 3) + fw + (m ? mw : 0);
    e.mcyc = m ? mw + 1 : 0;
    e.we = k == K_SW;
    e.rw = k <= K_LW || k == K_JAL;
    e.wb = k == K_LW ? 2'b01 : k == K_JAL ? 2'b10 : 2'b00;
    e.pw = tk || k == K_JAL;
    e.ps = k == K_JAL ? 2'b10 : tk ? 2'b01 : 2'b00;
    e.imm = k >= 7 && k <= K_SW;
    e.aop = 4'(AOP[k]);
    e.chk_alu = k != K_JAL;
    e.cnt = CW'(n_ret);
    n_ret++;
    sbq.push_back(e);
    fetch(fw);
    if (m) begin
      wait_dmem();
      repeat (mw) begin mif.ifetch_ready = 1'($urandom); step(); end
      mif.ifetch_ready = 1'b0;
      mif.dmem_ready = 1'b1;
      step();
      mif.dmem_ready = 1'b0;
    end
  endtask
  task automatic do_reset;
    rst_n = 1'b0;
    n_ret = 0;
    step();
    step();
    rst_n = 1'b1;
    run = 1'b1;
  endtask
  initial begin : monitor
    int lat = 0, mc = 0;
    logic ws = 1'b0, si = 1'b0;
    logic [3:0] sa = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        lat = 0; mc = 0; ws = 1'b0;
      end else begin
        if (state_o != 3'd0) lat++;
        if (state_o == 3'd3) begin sa = alu_op; si = alu_src_imm; end
        if (mif.dmem_req) begin mc++; ws |= mif.dmem_we; end
        if (retire) begin
          if (sbq.size() == 0) chk("unexpected_retire", retire, 0);
          else begin
            e = sbq.pop_front();
            chk("latency", lat, e.lat);
            chk("reg_write", reg_write, e.rw);
            chk("wb_sel", wb_sel, e.wb);
            chk("pc_write", pc_write, e.pw);
            if (e.pw) chk("pc_src", pc_src, e.ps);
            chk("alu_src_imm", si, e.imm);
            if (e.chk_alu) chk("alu_op", sa, e.aop);
            chk("dmem_cycles", mc, e.mcyc);
            chk("dmem_we", ws, e.we);
            chk("instr_count", instr_count, e.cnt);
          end
          lat = 0; mc = 0; ws = 1'b0;
        end
      end
    end
  end
  initial begin : stim
    mif.ifetch_ready = 1'b0;
    mif.dmem_ready = 1'b0;
    #1;
    chk("rst_state", state_o, 0);
    chk("rst_count", instr_count, 0);
    chk("rst_trap", trap, 0);
    chk("rst_ifetch_req", mif.ifetch_req, 0);
    chk("rst_ctrl", {ir_write, pc_write, pc_src, alu_src_imm, alu_op, mif.dmem_req, mif.dmem_we,
                     reg_write, wb_sel, retire}, 0);
    step();
    chk("idle_hold", state_o, 0);
    do_reset();
    issue(K_ADD, 0, 0, 0);
    issue(K_LW, 0, 3, 0);
    issue(K_BEQ, 0, 0, 1);
    issue(K_BEQ, 0, 0, 0);
    issue(K_JAL, 0, 0, 0);
    repeat (80) begin
      run = 1'($urandom);
      issue($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom));
    end
    wait_fetch();
    chk("drained", sbq.size(), 0);
    enc(K_SW, opcode, func3, func7);
    fetch(0);
    wait_dmem();
    step();
    chk("sw_mem_wait", mif.dmem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_dmem_req", mif.dmem_req, 0);
    chk("async_state", state_o, 0);
    chk("async_count", instr_count, 0);
    chk("async_trap", trap, 0);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      repeat (3) issue($urandom_range(0, 14), $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom));
      wait_fetch();
      illeg(i, opcode, func3, func7);
      fetch(0);
      step();
      repeat (6) begin
        run = 1'($urandom);
        mif.ifetch_ready = 1'($urandom);
        mif.dmem_ready = 1'($urandom);
        step();
        chk("trap", trap, 1);
        chk("trap_state", state_o, 7);
        chk("trap_count", instr_count, n_ret % (1 << CW));
        chk("trap_enables", {mif.ifetch_req, mif.dmem_req, reg_write, pc_write, ir_write}, 0);
      end
      mif.ifetch_ready = 1'b0;
      mif.dmem_ready = 1'b0;
      chk("trap_drained", sbq.size(), 0);
      do_reset();
      chk("trap_cleared", trap, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
